// File: rtl/barrel_hart_scheduler.sv
// Barrel-thread scheduler: round-robin issue over NUM_HARTS contexts,
// per-hart reset warm-up, and registered control bundles per stage.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   stall         freezes slot counter, warm-up and stage registers
//   hart_en       per-hart issue enable
//   ctrl_in       hart h control bundle at [h*CTRL_W +: CTRL_W]
//   hart_rst      per-hart reset to the Control instances
//   started       every hart has left reset
//   issue_hart    hart owning stage 0 (the slot counter)
//   stage_hart    owner of stage s at [s*HID_W +: HID_W]
//   stage_valid   stage s carries a live instruction
//   stage_ctrl    control bundle of stage s
module barrel_hart_scheduler #(
    parameter int NUM_HARTS  = 5,
    parameter int NUM_STAGES = 4,
    parameter int CTRL_W     = 64,
    localparam int HID_W     = $clog2(NUM_HARTS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [NUM_HARTS-1:0]         hart_en,
    input  logic [NUM_HARTS*CTRL_W-1:0]  ctrl_in,
    output logic [NUM_HARTS-1:0]         hart_rst,
    output logic                         started,
    output logic [HID_W-1:0]             issue_hart,
    output logic [NUM_STAGES*HID_W-1:0]  stage_hart,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_STAGES*CTRL_W-1:0] stage_ctrl
);

    logic [HID_W-1:0]     slot;
    logic [HID_W-1:0]     slot_nxt;
    logic [NUM_HARTS-1:0] hrst_q;
    logic [NUM_HARTS-1:0] hrst_nxt;
    logic                 started_q;

    logic                 v0;
    logic [CTRL_W-1:0]    ctrl0;

    logic [NUM_STAGES-1:1] vld_q;
    logic [HID_W-1:0]      hid_q  [1:NUM_STAGES-1];
    logic [CTRL_W-1:0]     ctrl_q [1:NUM_STAGES-1];

    assign slot_nxt = (slot == HID_W'(NUM_HARTS - 1)) ? '0 : slot + 1'b1;

    // Leaving slot h for the first time ends hart h's reset cycle.
    assign hrst_nxt = hrst_q & ~({{(NUM_HARTS-1){1'b0}}, 1'b1} << slot);

    assign v0    = hart_en[slot] & ~hrst_q[slot];
    assign ctrl0 = ctrl_in[int'(slot)*CTRL_W +: CTRL_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            slot      <= '0;
            hrst_q    <= '1;
            started_q <= 1'b0;
            vld_q     <= '0;
            for (int s = 1; s < NUM_STAGES; s++) begin
                hid_q[s]  <= '0;
                ctrl_q[s] <= '0;
            end
        end else if (!stall) begin
            slot      <= slot_nxt;
            hrst_q    <= hrst_nxt;
            started_q <= ~|hrst_nxt;
            vld_q[1]  <= v0;
            hid_q[1]  <= slot;
            ctrl_q[1] <= ctrl0;
            for (int s = 2; s < NUM_STAGES; s++) begin
                vld_q[s]  <= vld_q[s-1];
                hid_q[s]  <= hid_q[s-1];
                ctrl_q[s] <= ctrl_q[s-1];
            end
        end
    end

    assign hart_rst   = hrst_q;
    assign started    = started_q;
    assign issue_hart = slot;

    assign stage_valid[0]           = v0 & ~stall;
    assign stage_hart[0 +: HID_W]   = slot;
    assign stage_ctrl[0 +: CTRL_W]  = ctrl0;

    for (genvar s = 1; s < NUM_STAGES; s++) begin : g_stage
        assign stage_valid[s]              = vld_q[s] & ~stall;
        assign stage_hart[s*HID_W +: HID_W] = hid_q[s];
        assign stage_ctrl[s*CTRL_W +: CTRL_W] = ctrl_q[s];
    end

endmodule

// File: tb/tb_barrel_hart_scheduler.sv
// Scoreboard bench for barrel_hart_scheduler: directed 5-hart/4-stage
// scenarios plus an 8-hart/5-stage sweep with random enable and stall.
module tb_barrel_hart_scheduler;

    localparam int W  = 64;
    localparam int AH = 5;
    localparam int AS = 4;
    localparam int BH = 8;
    localparam int BS = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_a, stall_a;
    logic [AH-1:0]   en_a;
    logic [AH*W-1:0] ctrl_a;
    logic [AH-1:0]   hrst_a;
    logic            started_a;
    logic [2:0]      issue_a;
    logic [AS*3-1:0] sh_a;
    logic [AS-1:0]   sv_a;
    logic [AS*W-1:0] sc_a;

    logic            rst_b, stall_b;
    logic [BH-1:0]   en_b;
    logic [BH*W-1:0] ctrl_b;
    logic [BH-1:0]   hrst_b;
    logic            started_b;
    logic [2:0]      issue_b;
    logic [BS*3-1:0] sh_b;
    logic [BS-1:0]   sv_b;
    logic [BS*W-1:0] sc_b;

    barrel_hart_scheduler #(.NUM_HARTS(AH), .NUM_STAGES(AS), .CTRL_W(W)) dut_a (
        .clk(clk), .rst(rst_a), .stall(stall_a), .hart_en(en_a),
        .ctrl_in(ctrl_a), .hart_rst(hrst_a), .started(started_a),
        .issue_hart(issue_a), .stage_hart(sh_a), .stage_valid(sv_a),
        .stage_ctrl(sc_a)
    );

    barrel_hart_scheduler #(.NUM_HARTS(BH), .NUM_STAGES(BS), .CTRL_W(W)) dut_b (
        .clk(clk), .rst(rst_b), .stall(stall_b), .hart_en(en_b),
        .ctrl_in(ctrl_b), .hart_rst(hrst_b), .started(started_b),
        .issue_hart(issue_b), .stage_hart(sh_b), .stage_valid(sv_b),
        .stage_ctrl(sc_b)
    );

    typedef struct {
        int          cyc;
        string       name;
        int          fld;
        logic [63:0] val;
    } exp_t;

    exp_t q[$];
    int   gcyc  = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) gcyc <= gcyc + 1;

    task automatic ex(input string name, input int fld, input logic [63:0] val);
        exp_t e;
        e.cyc  = gcyc;
        e.name = name;
        e.fld  = fld;
        e.val  = val;
        q.push_back(e);
    endtask

    function automatic logic inv_b();
        for (int s = 0; s < BS; s++)
            if (sv_b[s] && sh_b[s*3 +: 3] != 3'(issue_b - 3'(s)))
                return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] peek(input int f);
        case (f)
            0:          return 64'(hrst_a);
            1:          return 64'(started_a);
            2:          return 64'(issue_a);
            3:          return 64'(sv_a);
            4:          return 64'(sh_a);
            5, 6, 7, 8: return sc_a[(f-5)*W +: W];
            10:         return 64'(started_b);
            11:         return 64'(issue_b);
            12:         return 64'(inv_b());
            13:         return 64'(sv_b);
            14:         return 64'(sv_b[0]);
            default:    return '1;
        endcase
    endfunction

    // Monitor: compares every expectation queued for the current cycle.
    initial begin
        exp_t        e;
        logic [63:0] got;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= gcyc) begin
                e   = q.pop_front();
                got = peek(e.fld);
                n_cmp++;
                if (e.cyc != gcyc || got !== e.val) begin
                    n_bad++;
                    $display("FAIL %s (cyc %0d): got %h want %h",
                             e.name, e.cyc, got, e.val);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals();
        ex("rst_hart_rst", 0, 64'h1f);
        ex("rst_started",  1, 64'h0);
        ex("rst_issue",    2, 64'h0);
        ex("rst_valid",    3, 64'h0);
        ex("rst_stage_hart", 4, 64'h0);
        ex("rst_ctrl1", 6, 64'h0);
        ex("rst_ctrl2", 7, 64'h0);
        ex("rst_ctrl3", 8, 64'h0);
    endtask

    task automatic reset_a();
        rst_a   = 1'b1;
        stall_a = 1'b0;
        step();
        reset_vals();
        step();
        rst_a = 1'b0;
    endtask

    initial begin
        int ns;
        int sl;
        rst_a = 1'b1; stall_a = 1'b0; en_a = '1;
        rst_b = 1'b1; stall_b = 1'b0; en_b = '1;
        for (int h = 0; h < AH; h++) ctrl_a[h*W +: W] = 64'h100 + 64'(h);
        for (int h = 0; h < BH; h++) ctrl_b[h*W +: W] = 64'h200 + 64'(h);

        // Warm-up, steady rotation, capture independence
        reset_a();
        n_cmp++;
        if (hrst_a !== 5'h1f) begin
            n_bad++;
            $display("FAIL direct_hart_rst: got %h want 1f", hrst_a);
        end
        n_cmp++;
        if (issue_a !== 3'd0) begin
            n_bad++;
            $display("FAIL direct_issue: got %h want 0", issue_a);
        end
        for (int c = 0; c <= 10; c++) begin
            if (c == 6) ctrl_a[0 +: W] = 64'hABC;
            case (c)
                0: begin
                    ex("A0_hart_rst", 0, 64'h1f);
                    ex("A0_valid",    3, 64'h0);
                end
                1: ex("A1_hart_rst", 0, 64'h1e);
                4: begin
                    ex("A4_hart_rst", 0, 64'h10);
                    ex("A4_started",  1, 64'h0);
                    ex("A4_valid",    3, 64'h0);
                end
                5: begin
                    ex("A5_hart_rst", 0, 64'h0);
                    ex("A5_started",  1, 64'h1);
                    ex("A5_valid",    3, 64'h1);
                    ex("A5_issue",    2, 64'h0);
                end
                6: begin
                    ex("A6_ctrl0", 5, 64'h101);
                    ex("A6_ctrl1", 6, 64'h100);
                end
                7: ex("A7_ctrl2", 7, 64'h100);
                8: begin
                    ex("A8_issue",      2, 64'h3);
                    ex("A8_stage_hart", 4, 64'h053);
                    ex("A8_valid",      3, 64'hf);
                    ex("A8_ctrl3",      8, 64'h100);
                end
                10: begin
                    ex("A10_issue", 2, 64'h0);
                    ex("A10_ctrl0", 5, 64'hABC);
                    ex("A10_ctrl3", 8, 64'h102);
                end
                default: ;
            endcase
            step();
        end

        // Hart 2 disabled from cycle 6
        ctrl_a[0 +: W] = 64'h100;
        reset_a();
        for (int c = 0; c <= 12; c++) begin
            if (c == 6) en_a[2] = 1'b0;
            case (c)
                7: begin
                    ex("B7_issue", 2, 64'h2);
                    ex("B7_valid", 3, 64'h6);
                end
                8:  ex("B8_valid", 3, 64'hd);
                9:  ex("B9_valid", 3, 64'hb);
                10: begin
                    ex("B10_valid",      3, 64'h7);
                    ex("B10_stage_hart", 4, 64'h4e0);
                end
                12: ex("B12_valid", 3, 64'he);
                default: ;
            endcase
            step();
        end
        en_a = '1;

        // Stall 10-12, then mid-run reset with stall at cycle 20
        reset_a();
        for (int c = 0; c <= 26; c++) begin
            stall_a = (c >= 10 && c <= 12) || c == 20;
            rst_a   = (c == 20);
            case (c)
                10: begin
                    ex("C10_valid",      3, 64'h0);
                    ex("C10_issue",      2, 64'h0);
                    ex("C10_stage_hart", 4, 64'h4e0);
                    ex("C10_ctrl3",      8, 64'h102);
                end
                11: begin
                    ex("C11_valid",      3, 64'h0);
                    ex("C11_issue",      2, 64'h0);
                    ex("C11_stage_hart", 4, 64'h4e0);
                    ex("C11_ctrl1",      6, 64'h104);
                end
                12: begin
                    ex("C12_valid",      3, 64'h0);
                    ex("C12_stage_hart", 4, 64'h4e0);
                    ex("C12_started",    1, 64'h1);
                end
                13: begin
                    ex("C13_valid",      3, 64'hf);
                    ex("C13_issue",      2, 64'h0);
                    ex("C13_stage_hart", 4, 64'h4e0);
                    ex("C13_ctrl1",      6, 64'h104);
                    ex("C13_ctrl3",      8, 64'h102);
                end
                14: ex("C14_issue", 2, 64'h1);
                20: ex("C20_valid", 3, 64'h0);
                21: reset_vals();
                25: begin
                    ex("C25_started",  1, 64'h0);
                    ex("C25_hart_rst", 0, 64'h10);
                end
                26: begin
                    ex("C26_started", 1, 64'h1);
                    ex("C26_valid",   3, 64'h1);
                    ex("C26_issue",   2, 64'h0);
                end
                default: ;
            endcase
            step();
        end

        // 8 harts / 5 stages: wrap, warm-up, random sweep
        rst_b = 1'b0;
        ns = 0;
        for (int c = 0; c <= 8; c++) begin
            ex("D_issue", 11, 64'(ns % BH));
            if (c == 0) ex("D0_started", 10, 64'h0);
            if (c == 7) ex("D7_started", 10, 64'h0);
            if (c == 8) ex("D8_started", 10, 64'h1);
            step();
            ns++;
        end
        for (int i = 0; i < 100; i++) begin
            stall_b = ($urandom_range(0, 3) == 0);
            en_b    = 8'($urandom);
            sl      = ns % BH;
            ex("D_rand_issue", 11, 64'(sl));
            ex("D_rand_invariant", 12, 64'h1);
            if (stall_b) ex("D_rand_stall_valid", 13, 64'h0);
            else         ex("D_rand_v0", 14, 64'(en_b[sl]));
            step();
            if (!stall_b) ns++;
        end
        stall_b = 1'b0;

        step();
        step();
        n_cmp++;
        if (started_b !== 1'b1) begin
            n_bad++;
            $display("FAIL direct_started_b: got %b want 1", started_b);
        end
        n_cmp++;
        if (hrst_b !== 8'h00) begin
            n_bad++;
            $display("FAIL direct_hart_rst_b: got %h want 00", hrst_b);
        end
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL %s (cyc %0d): never compared, want %h", e.name, e.cyc, e.val);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/barrel_hart_scheduler.md
# barrel_hart_scheduler

Parametrised barrel-thread scheduler for the multi-hart core. It generalises the fixed five-hart, counter-driven control mux into NUM_HARTS hart contexts sharing a NUM_STAGES pipeline. The block rotates issue ownership round-robin and sequences per-hart reset release. It carries each hart's control bundle through registered stage slots, and supports per-hart enable and a global stall. It sits between the per-hart Control instances and the shared Datapath, RegisterFile and Memory.

## Interface
- NUM_HARTS, 5: hart contexts; legal values are 2 to 16, and the value must be at least NUM_STAGES.
- NUM_STAGES, 4: pipeline stages (regread, execute, memory, writeback); legal values are 2 to 8.
- CTRL_W, 64: width of one hart's packed control bundle (addresses, rd/wr strobes, dp_ctrl, immediate, funct3).
- HID_W, derived as clog2(NUM_HARTS): hart-id width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  global freeze of the slot counter and stage registers.
- hart_en  in  NUM_HARTS  per-hart issue enable.
- ctrl_in  in  NUM_HARTS*CTRL_W  hart h bundle at [h*CTRL_W +: CTRL_W].
- hart_rst  out  NUM_HARTS  per-hart reset to the Control instances.
- started  out  1  high once every hart_rst bit has cleared.
- issue_hart  out  HID_W  hart owning stage 0 (equals slot).
- stage_hart  out  NUM_STAGES*HID_W  owner of stage s at [s*HID_W +: HID_W].
- stage_valid  out  NUM_STAGES  stage s carries a live instruction.
- stage_ctrl  out  NUM_STAGES*CTRL_W  control bundle for stage s.

## Operation
- slot counter: range 0 to NUM_HARTS-1. It increments on every non-stalled edge and wraps from NUM_HARTS-1 to 0.
- Reset release (warm-up):
  - hart_rst resets to all ones.
  - hart_rst[h] clears on the first non-stalled edge at which slot advances from h.
  - Net effect: the first revolution gives each hart exactly one reset cycle.
  - started = ~|hart_rst, registered together with hart_rst.
- Stage 0 is combinational from slot:
  - stage_hart[0] = slot.
  - stage_ctrl[0] = ctrl_in[slot].
  - issue valid v0 = hart_en[slot] & ~hart_rst[slot].
- Stages 1 to NUM_STAGES-1 are registered (valid, hart id, ctrl). On each non-stalled edge, stage s loads stage s-1, with stage 0 loading v0 and its live hart id and ctrl.
- Once captured, stage_ctrl[s] for s≥1 is independent of later ctrl_in changes.
- stage_valid[s]:
  - s=0: v0 & ~stall.
  - s≥1: registered valid & ~stall.
  - Consequence: all stage_valid bits read 0 during stall while registers hold.
- Invariant: for every valid stage s, stage_hart[s] == (slot - s) mod NUM_HARTS. No hart occupies two valid stages at once.
- hart_en low only suppresses new issue. In-flight entries for that hart complete and drain normally.
- Reset values:
  - slot = 0, hart_rst = all ones, started = 0.
  - Stage registers: valid 0, hart id 0, ctrl 0.
  - stage_valid = 0, issue_hart = 0.
- Priority: rst over stall over normal advance. Asserting rst mid-run discards all in-flight entries and restarts warm-up.

## Timing
- Cycle 0 is the first cycle with rst low.
- With no stall, hart_rst[h] is low from cycle h+1.
- started rises at cycle NUM_HARTS. This is also the first issue, by hart 0.
- Issue-to-stage-s latency is s non-stalled cycles. A hart reissues every NUM_HARTS non-stalled cycles.
- Stall cycles do not count toward warm-up or latency.
- hart_en and ctrl_in are sampled at the edge ending the cycle in which that hart holds stage 0.

## Test plan
- Reset release: rst for 2 cycles, then low; hart_en=5'b11111, stall=0.
  - hart_rst reads 11110 at cycle 1 and 00000 at cycle 5.
  - started rises at cycle 5.
  - Cycle 5: stage_valid[0]=1 with issue_hart=0.
- Steady rotation: ctrl_in[h]=0x100+h.
  - Cycle 8: issue_hart=3, stage_hart={0,1,2,3} for stages 3..0, stage_valid=4'b1111, stage_ctrl[3]=0x100.
  - Change ctrl_in[0] to 0xABC at cycle 6: stage_ctrl[2] at cycle 7 still reads 0x100.
- Hart disable: clear hart_en[2] from cycle 6.
  - Cycle 7 (slot 2): stage_valid[0]=0.
  - The bubble appears in stage 3 at cycle 10.
  - Harts 0, 1, 3 and 4 are unaffected.
- Stall: stall high for cycles 10-12.
  - stage_valid=0000 throughout.
  - slot, stage_hart and stage_ctrl are frozen.
  - Cycle 13 shows the cycle-10 values with valid restored.
- Mid-run reset: rst and stall both high at cycle 20.
  - Cycle 21: all outputs at reset values.
  - Warm-up repeats with started rising 5 cycles after rst falls.
- Parameter sweep at NUM_HARTS=8, NUM_STAGES=5:
  - slot wraps from 7 to 0.
  - started rises at cycle 8.
  - The invariant stage_hart[s]==(slot-s) mod 8 holds for 100 random cycles with random hart_en and stall.
